tlul_err_responder: RTL and testbench

TLUL_ERR_RESPONDER -- requirements
Module: tlul_err_responder

---
 rtl/tlul_pkg.sv | 48 ++++
 rtl/tlul_err_responder.sv | 111 +++++++++++
 tb/tb_tlul_err_responder.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tlul_pkg.sv
// Minimal TL-UL bus package: bus widths, channel opcodes and the A/D channel structs.
package tlul_pkg;

  localparam int unsigned TL_AW  = 32;
  localparam int unsigned TL_DW  = 32;
  localparam int unsigned TL_AIW = 8;
  localparam int unsigned TL_DIW = 1;
  localparam int unsigned TL_SZW = 2;
  localparam int unsigned TL_UW  = 16;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic                a_valid;
    tl_a_op_e            a_opcode;
    logic [2:0]          a_param;
    logic [TL_SZW-1:0]   a_size;
    logic [TL_AIW-1:0]   a_source;
    logic [TL_AW-1:0]    a_address;
    logic [TL_DW/8-1:0]  a_mask;
    logic [TL_DW-1:0]    a_data;
    logic [TL_UW-1:0]    a_user;
    logic                d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic                d_valid;
    tl_d_op_e            d_opcode;
    logic [2:0]          d_param;
    logic [TL_SZW-1:0]   d_size;
    logic [TL_AIW-1:0]   d_source;
    logic [TL_DIW-1:0]   d_sink;
    logic [TL_DW-1:0]    d_data;
    logic [TL_UW-1:0]    d_user;
    logic                d_error;
    logic                a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/tlul_err_responder.sv
// Sink for TL-UL requests that failed a protocol check or decode: answers each with
// an error response (one outstanding at most) and keeps a saturating error count.
module tlul_err_responder
  import tlul_pkg::*;
#(
  parameter logic [31:0] ErrData = '1,
  parameter int unsigned CntW    = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  tl_h2d_t         tl_h_i,
  output tl_d2h_t         tl_h_o,
  input  logic            cnt_clr_i,
  output logic [CntW-1:0] err_cnt_o
);

  typedef enum logic {
    IDLE = 1'b0,
    RSP  = 1'b1
  } state_e;

  state_e              state_reg, state_next;
  logic                a_ready, a_hs, d_valid;
  tl_d_op_e            d_opcode_reg;
  logic [TL_SZW-1:0]   d_size_reg;
  logic [TL_AIW-1:0]   d_source_reg;
  logic [TL_DW-1:0]    d_data_reg;
  logic                d_error_reg;
  logic [CntW-1:0]     cnt_reg, cnt_next;

  // Draining the held response frees the slot, so a new request can land the same cycle.
  assign a_ready = (state_reg == IDLE) | tl_h_i.d_ready;
  assign a_hs    = tl_h_i.a_valid & a_ready;

  always_comb begin
    state_next = state_reg;
    d_valid    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (a_hs) state_next = RSP;
      end
      RSP: begin
        d_valid = 1'b1;
        if (!a_hs && tl_h_i.d_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg    <= IDLE;
      d_opcode_reg <= AccessAck;
      d_size_reg   <= '0;
      d_source_reg <= '0;
      d_data_reg   <= '0;
      d_error_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (a_hs) begin
        d_opcode_reg <= (tl_h_i.a_opcode == Get) ? AccessAckData : AccessAck;
        d_data_reg   <= (tl_h_i.a_opcode == Get) ? ErrData : '0;
        d_size_reg   <= tl_h_i.a_size;
        d_source_reg <= tl_h_i.a_source;
        d_error_reg  <= 1'b1;
      end
    end
  end

  // Clear wins over increment, but a coinciding request still counts as the first error.
  always_comb begin
    cnt_next = cnt_reg;
    if (cnt_clr_i) begin
      cnt_next = a_hs ? CntW'(1) : '0;
    end else if (a_hs && (cnt_reg != {CntW{1'b1}})) begin
      cnt_next = cnt_reg + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_reg <= '0;
    else         cnt_reg <= cnt_next;
  end

  assign err_cnt_o = cnt_reg;

  always_comb begin
    tl_h_o          = '0;
    tl_h_o.a_ready  = a_ready;
    tl_h_o.d_valid  = d_valid;
    tl_h_o.d_opcode = d_opcode_reg;
    tl_h_o.d_size   = d_size_reg;
    tl_h_o.d_source = d_source_reg;
    tl_h_o.d_data   = d_data_reg;
    tl_h_o.d_error  = d_error_reg;
  end

  logic unused_a_fields;
  assign unused_a_fields = ^{tl_h_i.a_param, tl_h_i.a_address, tl_h_i.a_mask,
                             tl_h_i.a_data, tl_h_i.a_user};

  data_width_is_32: assert property (@(posedge clk_i) TL_DW == 32);

  d_stable_under_backpressure: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (tl_h_o.d_valid && !tl_h_i.d_ready) |=>
      ($stable(tl_h_o.d_valid) && $stable(tl_h_o.d_opcode) && $stable(tl_h_o.d_size) &&
       $stable(tl_h_o.d_source) && $stable(tl_h_o.d_data) && $stable(tl_h_o.d_error) &&
       $stable(tl_h_o.d_param) && $stable(tl_h_o.d_sink) && $stable(tl_h_o.d_user)));

endmodule

// File: tb/tb_tlul_err_responder.sv
// Randomised self-checking bench for tlul_err_responder against a one-slot response model.
module tb_tlul_err_responder;
  import tlul_pkg::*;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  tl_h2d_t          tl_h_i;
  tl_d2h_t          tl_h_o;
  logic             cnt_clr_i;
  logic [CNT_W-1:0] err_cnt_o;

  int checks = 0;
  int errors = 0;

  // Reference model: at most one pending response plus an integer error count.
  bit         m_pend;
  logic [2:0] m_op;
  logic [1:0] m_size;
  logic [7:0] m_src;
  int         m_cnt;
  logic       obs_aready, exp_aready;

  always #5 clk_i = ~clk_i;

  tlul_err_responder #(.ErrData(32'hFFFF_FFFF), .CntW(CNT_W)) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .tl_h_i    (tl_h_i),
    .tl_h_o    (tl_h_o),
    .cnt_clr_i (cnt_clr_i),
    .err_cnt_o (err_cnt_o)
  );

  function automatic logic [65:0] exp_d();
    return {(m_op == 3'h4) ? 3'h1 : 3'h0, 1'b1, m_size, m_src,
            (m_op == 3'h4) ? 32'hFFFF_FFFF : 32'h0, 3'h0, 1'b0, 16'h0};
  endfunction

  function automatic logic [65:0] obs_d();
    return {tl_h_o.d_opcode, tl_h_o.d_error, tl_h_o.d_size, tl_h_o.d_source,
            tl_h_o.d_data, tl_h_o.d_param, tl_h_o.d_sink, tl_h_o.d_user};
  endfunction

  // One clock cycle from negedge to negedge; drives inputs and advances the model only.
  task automatic cycle(input bit av, input logic [2:0] op, input logic [1:0] sz,
                       input logic [7:0] src, input bit dr, input bit clr);
    bit hs;
    tl_h_i           = '0;
    tl_h_i.a_valid   = av;
    tl_h_i.a_opcode  = tl_a_op_e'(op);
    tl_h_i.a_size    = sz;
    tl_h_i.a_source  = src;
    tl_h_i.a_address = $urandom;
    tl_h_i.a_data    = $urandom;
    tl_h_i.a_mask    = 4'($urandom);
    tl_h_i.a_param   = 3'($urandom);
    tl_h_i.a_user    = 16'($urandom);
    tl_h_i.d_ready   = dr;
    cnt_clr_i        = clr;
    #1;
    obs_aready = tl_h_o.a_ready;
    exp_aready = !m_pend || dr;
    hs = av && exp_aready;
    @(posedge clk_i);
    if (m_pend && dr) m_pend = 1'b0;
    if (hs) begin
      m_pend = 1'b1; m_op = op; m_size = sz; m_src = src;
      $display("A req: op=%0h size=%0d src=%02h", op, sz, src);
    end
    if (clr) m_cnt = hs ? 1 : 0;
    else if (hs && m_cnt < CNT_MAX) m_cnt++;
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    tl_h_i = '0; cnt_clr_i = 1'b0;
    m_pend = 1'b0; m_cnt = 0; m_op = '0; m_size = '0; m_src = '0;
    repeat (3) @(negedge clk_i);
    checks++;
    if (tl_h_o.d_valid !== 1'b0 || err_cnt_o !== 4'd0 || obs_d() !== 66'h0) begin
      errors++;
      $display("FAIL reset_values: d_valid=%b cnt=%0d d=%h, required 0/0/0",
               tl_h_o.d_valid, err_cnt_o, obs_d());
    end
    rst_ni = 1'b1;
    #1;
    checks++;
    if (tl_h_o.a_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_a_ready: a_ready=%b, required 1", tl_h_o.a_ready);
    end
    @(negedge clk_i);
  endtask

  task automatic test_single_get();
    cycle(1, 3'h4, 2'd2, 8'h05, 1, 0);
    checks++;
    if (tl_h_o.d_valid !== 1'b1 || obs_d() !== exp_d() ||
        tl_h_o.d_data !== 32'hFFFF_FFFF || tl_h_o.d_source !== 8'h05 || err_cnt_o !== 4'd1) begin
      errors++;
      $display("FAIL single_get: v=%b d=%h cnt=%0d, required v=1 d=%h cnt=1",
               tl_h_o.d_valid, obs_d(), err_cnt_o, exp_d());
    end
    cycle(0, 3'h4, 2'd0, 8'h00, 1, 0);
    checks++;
    if (tl_h_o.d_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_get_drain: d_valid=%b, required 0", tl_h_o.d_valid);
    end
  endtask

  task automatic test_put_backpressure();
    cycle(1, 3'h0, 2'd1, 8'h3C, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 3'h4, 2'd2, 8'h77, 0, 0);
      checks++;
      if (obs_aready !== 1'b0 || tl_h_o.d_valid !== 1'b1 || obs_d() !== exp_d() ||
          tl_h_o.d_opcode !== AccessAck || tl_h_o.d_data !== 32'h0) begin
        errors++;
        $display("FAIL put_backpressure[%0d]: a_ready=%b v=%b d=%h, required 0/1/%h",
                 i, obs_aready, tl_h_o.d_valid, obs_d(), exp_d());
      end
    end
    cycle(0, 3'h0, 2'd0, 8'h00, 1, 0);
    checks++;
    if (tl_h_o.d_valid !== 1'b0 || err_cnt_o !== 4'(m_cnt)) begin
      errors++;
      $display("FAIL put_release: v=%b cnt=%0d, required 0/%0d", tl_h_o.d_valid, err_cnt_o, m_cnt);
    end
  endtask

  task automatic test_back_to_back();
    cycle(0, 3'h0, 2'd0, 8'h00, 1, 1);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 3'h4, 2'd2, 8'(8'h10 + i), 1, 0);
      checks++;
      if (obs_aready !== 1'b1 || tl_h_o.d_valid !== 1'b1 || tl_h_o.d_source !== 8'(8'h10 + i) ||
          obs_d() !== exp_d()) begin
        errors++;
        $display("FAIL back_to_back[%0d]: a_ready=%b v=%b src=%02h, required 1/1/%02h",
                 i, obs_aready, tl_h_o.d_valid, tl_h_o.d_source, 8'(8'h10 + i));
      end
    end
    cycle(0, 3'h0, 2'd0, 8'h00, 1, 0);
    checks++;
    if (err_cnt_o !== 4'd4 || tl_h_o.d_valid !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back_cnt: cnt=%0d v=%b, required 4/0", err_cnt_o, tl_h_o.d_valid);
    end
  endtask

  task automatic test_illegal_opcode();
    cycle(1, 3'h7, 2'd0, 8'hA5, 1, 0);
    checks++;
    if (tl_h_o.d_valid !== 1'b1 || tl_h_o.d_opcode !== AccessAck || tl_h_o.d_error !== 1'b1 ||
        tl_h_o.d_data !== 32'h0 || obs_d() !== exp_d()) begin
      errors++;
      $display("FAIL illegal_opcode: d=%h, required %h", obs_d(), exp_d());
    end
    cycle(0, 3'h7, 2'd3, 8'hFF, 1, 0);
  endtask

  task automatic test_counter_sat_clear();
    cycle(0, 3'h0, 2'd0, 8'h00, 1, 1);
    for (int i = 0; i < 17; i++) cycle(1, 3'h1, 2'd1, 8'(i), 1, 0);
    checks++;
    if (err_cnt_o !== 4'd15 || err_cnt_o !== 4'(m_cnt)) begin
      errors++;
      $display("FAIL cnt_saturate: cnt=%0d, required 15", err_cnt_o);
    end
    cycle(1, 3'h4, 2'd2, 8'h42, 1, 1);
    checks++;
    if (err_cnt_o !== 4'd1) begin
      errors++;
      $display("FAIL cnt_clear_with_req: cnt=%0d, required 1", err_cnt_o);
    end
    cycle(0, 3'h4, 2'd2, 8'h42, 1, 1);
    checks++;
    if (err_cnt_o !== 4'd0 || tl_h_o.d_valid !== 1'b0) begin
      errors++;
      $display("FAIL cnt_clear_alone: cnt=%0d v=%b, required 0/0", err_cnt_o, tl_h_o.d_valid);
    end
  endtask

  task automatic test_random();
    logic [2:0] op;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0: op = 3'h0;
        1: op = 3'h1;
        2: op = 3'h4;
        default: op = 3'($urandom_range(0, 7));
      endcase
      cycle(bit'($urandom_range(0, 1)), op, 2'($urandom), 8'($urandom),
            bit'($urandom_range(0, 2) != 0), bit'($urandom_range(0, 19) == 0));
      checks++;
      if (obs_aready !== exp_aready || tl_h_o.d_valid !== m_pend ||
          (m_pend && obs_d() !== exp_d()) || err_cnt_o !== 4'(m_cnt)) begin
        errors++;
        $display("FAIL random[%0d]: a_ready=%b v=%b d=%h cnt=%0d, required %b/%b/%h/%0d",
                 i, obs_aready, tl_h_o.d_valid, obs_d(), err_cnt_o,
                 exp_aready, m_pend, exp_d(), m_cnt);
      end
    end
  endtask

  task automatic test_reset_in_rsp();
    cycle(1, 3'h4, 2'd2, 8'h99, 0, 0);
    checks++;
    if (tl_h_o.d_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_rsp_setup: d_valid=%b, required 1", tl_h_o.d_valid);
    end
    tl_h_i.a_valid = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    m_pend = 1'b0; m_cnt = 0;
    checks++;
    if (tl_h_o.d_valid !== 1'b0 || err_cnt_o !== 4'd0 || obs_d() !== 66'h0) begin
      errors++;
      $display("FAIL reset_in_rsp: v=%b cnt=%0d d=%h, required 0/0/0",
               tl_h_o.d_valid, err_cnt_o, obs_d());
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(0, 3'h4, 2'd0, 8'h00, bit'(i == 0 ? 0 : 1), 0);
      checks++;
      if (tl_h_o.d_valid !== 1'b0 || err_cnt_o !== 4'd0) begin
        errors++;
        $display("FAIL reset_no_stale[%0d]: v=%b cnt=%0d, required 0/0",
                 i, tl_h_o.d_valid, err_cnt_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_get();
    test_put_backpressure();
    test_back_to_back();
    test_illegal_opcode();
    test_counter_sat_clear();
    test_random();
    test_reset_in_rsp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
